// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: receive-side TDM link bundle.
//   m          - slot word, WIDTH bits
//   m_valid    - beat qualifier, one slot word per cycle while high
//   frame_sync - marks the current valid beat as slot 0
// Modports: master drives the link (source side), slave receives it (demux side).
interface tdm_demux4_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] m;
  logic             m_valid;
  logic             frame_sync;

  modport master (output m, output m_valid, output frame_sync);
  modport slave  (input  m, input  m_valid, input  frame_sync);
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: time-division 1-to-4 demultiplexer.
// Collects slot words from the TDM link into shadow registers and publishes
// all four channels together, one clock after the slot-3 beat is accepted.
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous reset, active-high
//   bus          - tdm_demux4_if.slave (m, m_valid, frame_sync)
//   y0..y3       - channel words of the last complete frame
//   c            - slot index the next accepted beat lands in
//   locked       - high while in LOCKED
//   frame_valid  - one-cycle pulse, y0..y3 updated this cycle
//   sync_err     - one-cycle pulse, frame_sync seen at a slot other than 0
//   frame_cnt    - completed-frame count, 16 bits, wraps   (TDM_DEMUX_FRAME_CNT_EN)
//   err_cnt      - sync_err count, 8 bits, saturates       (TDM_DEMUX_FRAME_CNT_EN)
// Optional feature macro: TDM_DEMUX_FRAME_CNT_EN.
//
// state  | meaning
// HUNT   | waiting for a frame_sync beat, all other beats discarded
// LOCKED | aligned; beats steered to shadow[c]
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  tdm_demux4_if.slave      bus,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [1:0]       c,
`ifdef TDM_DEMUX_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt,
`endif
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      c           <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bus.m_valid) begin
        if (state == HUNT) begin
          if (bus.frame_sync) begin
            sh0   <= bus.m;
            c     <= 2'd1;
            state <= LOCKED;
          end
        end else if (bus.frame_sync) begin
          // A sync beat always restarts the frame; only a misaligned one is an error.
          sh0      <= bus.m;
          c        <= 2'd1;
          sync_err <= (c != 2'd0);
        end else begin
          case (c)
            2'd0: sh0 <= bus.m;
            2'd1: sh1 <= bus.m;
            2'd2: sh2 <= bus.m;
            default: begin
              // Slot 3 comes straight from the link so the whole frame loads in one edge.
              y0          <= sh0;
              y1          <= sh1;
              y2          <= sh2;
              y3          <= bus.m;
              frame_valid <= 1'b1;
            end
          endcase
          c <= c + 2'd1;
        end
      end
    end
  end

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic frame_done;
  logic err_hit;

  assign frame_done = bus.m_valid && (state == LOCKED) && !bus.frame_sync && (c == 2'd3);
  assign err_hit    = bus.m_valid && (state == LOCKED) &&  bus.frame_sync && (c != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 8'd0;
    end else begin
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err_hit && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;
  localparam int WIDTH = 1;

  logic clk;
  logic rst;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [1:0] c;
  logic locked, frame_valid, sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int checks;
  int failures;

  tdm_demux4_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .c           (c),
`ifdef TDM_DEMUX_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
`endif
    .locked      (locked),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of link inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic mm, input logic fs);
    bus.m_valid    = v;
    bus.m          = mm;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  // Full frame at full rate; d[3] is slot 0.
  task automatic frame(input logic [3:0] d);
    for (int s = 0; s < 4; s++) step(1'b1, d[3-s], s == 0);
  endtask

  logic [3:0] frames [3];

  initial begin
    checks   = 0;
    failures = 0;
    bus.m = '0; bus.m_valid = 1'b0; bus.frame_sync = 1'b0;
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_y", {y0, y1, y2, y3}, 4'b0000);
    chk("rst_c", c, 2'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_serr", sync_err, 1'b0);
    rst = 1'b0;

    // 1: lock entry and first frame 1,0,1,1
    step(1, 1, 1);
    chk("t1_locked", locked, 1'b1);
    chk("t1_c1", c, 2'd1);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("t1_c3", c, 2'd3);
    chk("t1_fv_early", frame_valid, 1'b0);
    step(1, 1, 0);
    chk("t1_fv", frame_valid, 1'b1);
    chk("t1_y", {y0, y1, y2, y3}, 4'b1011);
    chk("t1_c0", c, 2'd0);
    step(0, 0, 0);
    chk("t1_fv_pulse", frame_valid, 1'b0);
    chk("t1_y_hold", {y0, y1, y2, y3}, 4'b1011);

    // 2: hunt discard
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      chk("t2_hunt_locked", locked, 1'b0);
      chk("t2_hunt_fv", frame_valid, 1'b0);
    end
    frame(4'b0110);
    chk("t2_fv", frame_valid, 1'b1);
    chk("t2_y", {y0, y1, y2, y3}, 4'b0110);

    // 3: gapped beats 1,1,0,1 with 2 idle cycles between beats
    step(1, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t3_c_gap1", c, 2'd1);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    chk("t3_c_gap2", c, 2'd2);
    chk("t3_y_hold", {y0, y1, y2, y3}, 4'b0110);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t3_c_gap3", c, 2'd3);
    chk("t3_fv_gap", frame_valid, 1'b0);
    step(1, 1, 0);
    chk("t3_fv", frame_valid, 1'b1);
    chk("t3_y", {y0, y1, y2, y3}, 4'b1101);

    // 4: early sync on 3rd beat; that beat is slot 0 of frame 0,0,1,1
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("t4_serr", sync_err, 1'b1);
    chk("t4_fv_broken", frame_valid, 1'b0);
    chk("t4_c", c, 2'd1);
    chk("t4_locked", locked, 1'b1);
    chk("t4_y_hold", {y0, y1, y2, y3}, 4'b1101);
    step(1, 0, 0);
    chk("t4_serr_pulse", sync_err, 1'b0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("t4_fv", frame_valid, 1'b1);
    chk("t4_serr_clean", sync_err, 1'b0);
    chk("t4_y", {y0, y1, y2, y3}, 4'b0011);

    // 5: full-rate back-to-back frames, then reset mid-frame
    frames[0] = 4'b1000;
    frames[1] = 4'b0100;
    frames[2] = 4'b0011;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b1, frames[f][3-s], s == 0);
        chk("t5_fv", frame_valid, (s == 3) ? 1'b1 : 1'b0);
        chk("t5_serr", sync_err, 1'b0);
      end
      chk("t5_y", {y0, y1, y2, y3}, frames[f]);
    end
    step(1, 1, 1);
    step(1, 1, 0);
    rst = 1'b1;
    step(1, 1, 0);
    rst = 1'b0;
    chk("t5_rst_y", {y0, y1, y2, y3}, 4'b0000);
    chk("t5_rst_locked", locked, 1'b0);
    chk("t5_rst_c", c, 2'd0);
    chk("t5_rst_fv", frame_valid, 1'b0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("t5_after_rst_fv", frame_valid, 1'b0);
    chk("t5_after_rst_locked", locked, 1'b0);

    // 6: 5 good frames and 2 early syncs
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    frame(4'b1010);
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 0, 1);
    chk("t6_serr1", sync_err, 1'b1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("t6_y2", {y0, y1, y2, y3}, 4'b0101);
    frame(4'b1111);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 1, 1);
    chk("t6_serr2", sync_err, 1'b1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    chk("t6_y4", {y0, y1, y2, y3}, 4'b1110);
    frame(4'b0001);
    chk("t6_y5", {y0, y1, y2, y3}, 4'b0001);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("t6_frame_cnt", frame_cnt, 16'd5);
    chk("t6_err_cnt", err_cnt, 8'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Time-division 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 channel mux.
- Accepts a serial stream of slot words on m, one per m_valid beat, framed by frame_sync.
- Steers each beat into channel 0..3 by an internal slot counter.
- Publishes all four channels together once per complete frame.
- Sits between the TDM link and the per-channel consumers.

Parameters:
WIDTH, 1, bit width of each slot word and of each channel output y0..y3.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
m  input  WIDTH  incoming slot word; sampled only when m_valid=1.
m_valid  input  1  beat qualifier; one slot word per cycle with m_valid=1.
frame_sync  input  1  marks the current m_valid beat as slot 0; ignored when m_valid=0.
y0  output  WIDTH  channel 0 word of the last complete frame.
y1  output  WIDTH  channel 1 word of the last complete frame.
y2  output  WIDTH  channel 2 word of the last complete frame.
y3  output  WIDTH  channel 3 word of the last complete frame.
c  output  2  slot index the next accepted beat will be written to (valid in LOCKED).
locked  output  1  1 while the FSM is in LOCKED.
frame_valid  output  1  one-cycle pulse: y0..y3 were updated this cycle.
sync_err  output  1  one-cycle pulse: frame_sync arrived at a slot other than 0; partial frame dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - y0..y3=0, c=0, locked=0, frame_valid=0, sync_err=0.
  - Shadow registers cleared; FSM to HUNT.
  - Reset mid-frame discards the partial frame with no frame_valid pulse.
- FSM states: HUNT, LOCKED.
- HUNT:
  - Beats without frame_sync are discarded.
  - A beat with m_valid=1 and frame_sync=1 writes m to shadow slot 0, sets c=1 and moves to LOCKED.
- LOCKED, beat with m_valid=1 and frame_sync=0:
  - m is written to shadow[c], then c increments mod 4.
  - Frame completes when the beat lands in slot 3 and c wraps to 0.
- LOCKED, beat with m_valid=1 and frame_sync=1:
  - When c==0: normal start of the next frame (m to shadow 0, c=1).
  - When c!=0: sync_err pulses next cycle, the partial frame is discarded, this beat becomes slot 0 (c=1), and the FSM stays LOCKED.
- m_valid=0: no state change; a gap of any length between beats is allowed.
- Frame completion:
  - On the clock edge that accepts the slot-3 beat, y0..y3 load atomically from shadow 0..2 plus the current m.
  - frame_valid is high for exactly the following cycle.
  - Latency from slot-3 beat to outputs: 1 clock.
- Outputs hold their value between frames. Channel outputs never show a mix of two frames.
- Back-to-back frames at full rate (m_valid held at 1) yield one frame_valid pulse every 4 cycles.
- The registered sync_err and frame_valid are never asserted in the same cycle. A frame_sync beat with c==0 never raises sync_err.
- Loss of lock: none. Only rst returns the FSM to HUNT.

Optional Feature:
TDM_DEMUX_FRAME_CNT_EN:
- Defined:
  - Adds output frame_cnt (16 bits): a count of completed frames.
  - Increments in the same cycle frame_valid is asserted; wraps 0xFFFF to 0x0000.
  - Cleared by rst.
  - Adds output err_cnt (8 bits): counts sync_err pulses and saturates at 0xFF.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
1. Reset then locked entry:
   - Stimulus: rst for 2 cycles, then beats 1,0,1,1 with frame_sync on the first beat (WIDTH=1).
   - Required: locked=1 after the first beat; one cycle after the 4th beat y0..y3=1,0,1,1 with a single frame_valid pulse.
2. Hunt discard:
   - Stimulus: 3 beats without frame_sync after reset, then a framed 0,1,1,0.
   - Required: locked=0 and no frame_valid during the first 3 beats; y0..y3=0,1,1,0 after the frame.
3. Gapped beats:
   - Stimulus: frame 1,1,0,1 with 2 idle cycles (m_valid=0) between each beat.
   - Required: c advances only on beats; y unchanged until the last beat; then y=1,1,0,1.
4. Early sync:
   - Stimulus: frame_sync on the 3rd beat of a frame, followed by a full frame 0,0,1,1.
   - Required: sync_err pulses once; no frame_valid for the broken frame; then y=0,0,1,1; the previous y is held in between.
5. Full-rate back-to-back frames plus mid-frame reset:
   - Stimulus: 3 frames with m_valid=1 continuously, then rst asserted after 2 beats of frame 4.
   - Required: frame_valid every 4 cycles, 3 pulses total; after rst all outputs are 0 and locked=0.
6. With TDM_DEMUX_FRAME_CNT_EN defined:
   - Stimulus: 5 good frames and 2 early syncs.
   - Required: frame_cnt=5 and err_cnt=2.
